// File: rtl/rr_pkt_arbiter.sv
// Round-robin grant arbiter with a registered, locked one-hot grant and a rotating priority pointer.
// Optional watchdog forced release is built when ARB_TIMEOUT_EN is defined.
module rr_pkt_arbiter #(
    parameter int ARB_NUM     = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       iClk,
    input  logic                       iRst_n,
    input  logic [ARB_NUM-1:0]         iReq,
    input  logic                       iDone,
    output logic [ARB_NUM-1:0]         oGnt,
    output logic [$clog2(ARB_NUM)-1:0] oGntIdx,
    output logic                       oBusy,
    output logic                       oTimeout
);
    localparam int IDX_W = $clog2(ARB_NUM);

    if (ARB_NUM < 2 || ARB_NUM > 32 || TIMEOUT_CYC < 2) begin : g_bad_param
        $error("rr_pkt_arbiter: ARB_NUM must be 2..32 and TIMEOUT_CYC at least 2");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   ptr, ptr_nx, ptr_rel, sel_ptr, win_idx, idx_nx;
    logic [IDX_W:0]     cand;
    logic [ARB_NUM-1:0] gnt_nx;
    logic               win_vld, force_rel, release_now, load;

    // Pointer the owner hands over to on release; owner ARB_NUM-1 wraps to 0.
    assign ptr_rel = (oGntIdx == IDX_W'(ARB_NUM - 1)) ? '0 : oGntIdx + 1'b1;
    assign sel_ptr = (state == BUSY) ? ptr_rel : ptr;

    // Rotating priority scan starting at sel_ptr.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < ARB_NUM; i++) begin
            cand = {1'b0, sel_ptr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(ARB_NUM))
                cand = cand - (IDX_W+1)'(ARB_NUM);
            if (!win_vld && iReq[cand[IDX_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[IDX_W-1:0];
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             tout_q;

    assign force_rel = (state == BUSY) && !iDone && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign cnt_nx    = (state_nx == BUSY && !load) ? cnt + 1'b1 : '0;
    assign oTimeout  = tout_q;

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            cnt    <= '0;
            tout_q <= 1'b0;
        end else begin
            cnt    <= cnt_nx;
            tout_q <= force_rel;
        end
    end
`else
    assign force_rel = 1'b0;
    assign oTimeout  = 1'b0;
`endif

    assign release_now = (state == BUSY) && (iDone || force_rel);
    assign oBusy       = (state == BUSY);

    always_comb begin
        state_nx = state;
        gnt_nx   = oGnt;
        idx_nx   = oGntIdx;
        ptr_nx   = ptr;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nx = BUSY;
                    load     = 1'b1;
                end
            end
            BUSY: begin
                if (release_now) begin
                    ptr_nx = ptr_rel;
                    if (win_vld) begin
                        load = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        gnt_nx   = '0;
                        idx_nx   = '0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        if (load) begin
            gnt_nx = ARB_NUM'(1) << win_idx;
            idx_nx = win_idx;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state   <= IDLE;
            oGnt    <= '0;
            oGntIdx <= '0;
            ptr     <= '0;
        end else begin
            state   <= state_nx;
            oGnt    <= gnt_nx;
            oGntIdx <= idx_nx;
            ptr     <= ptr_nx;
        end
    end
endmodule

// File: tb/tb_rr_pkt_arbiter.sv
// Scoreboard bench for rr_pkt_arbiter: directed scenarios followed by random traffic,
// checked against a distance-based round-robin reference model.
module tb_rr_pkt_arbiter;
    localparam int N  = 8;
    localparam int TC = 16;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         iClk = 1'b0;
    logic         iRst_n = 1'b0;
    logic [N-1:0] iReq = '0;
    logic         iDone = 1'b0;
    logic [N-1:0] oGnt;
    logic [2:0]   oGntIdx;
    logic         oBusy;
    logic         oTimeout;

    rr_pkt_arbiter #(.ARB_NUM(N), .TIMEOUT_CYC(TC)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iReq(iReq), .iDone(iDone),
        .oGnt(oGnt), .oGntIdx(oGntIdx), .oBusy(oBusy), .oTimeout(oTimeout)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [N-1:0] gnt;
        logic [2:0]   idx;
        logic         busy;
        logic         tout;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    int m_ptr = 0, m_own = 0, m_cnt = 0;
    bit m_busy = 0;

    // Winner is the requester with the smallest forward distance from the pointer.
    function automatic int winner(input logic [N-1:0] req, input int p);
        int best = -1, bd = N;
        for (int i = 0; i < N; i++)
            if (req[i] && ((i - p + N) % N) < bd) begin
                bd   = (i - p + N) % N;
                best = i;
            end
        return best;
    endfunction

    task automatic cyc(input bit rst_n, input logic [N-1:0] req, input bit done);
        exp_t e;
        bit   frc = 1'b0;
        @(negedge iClk);
        iRst_n = rst_n;
        iReq   = req;
        iDone  = done;
        if (!rst_n) begin
            m_ptr = 0; m_own = 0; m_cnt = 0; m_busy = 0;
        end else if (!m_busy) begin
            if (req != 0) begin
                m_own = winner(req, m_ptr); m_busy = 1; m_cnt = 0;
            end
        end else begin
            if (TO_EN && !done && m_cnt == TC - 1) frc = 1'b1;
            if (done || frc) begin
                m_ptr = (m_own + 1) % N;
                m_cnt = 0;
                if (req != 0) m_own = winner(req, m_ptr);
                else          m_busy = 0;
            end else begin
                m_cnt++;
            end
        end
        e.gnt  = m_busy ? N'(1) << m_own : '0;
        e.idx  = 3'(m_own);
        e.busy = m_busy;
        e.tout = frc;
        q.push_back(e);
    endtask

    // Monitor: one expected entry per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge iClk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (oGnt !== e.gnt || oBusy !== e.busy || oTimeout !== e.tout ||
                    (e.busy && oGntIdx !== e.idx)) begin
                    n_err++;
                    $display("FAIL vec%0d: got gnt=%h idx=%0d busy=%b to=%b, want gnt=%h idx=%0d busy=%b to=%b",
                             n_vec, oGnt, oGntIdx, oBusy, oTimeout, e.gnt, e.idx, e.busy, e.tout);
                end
            end
        end
    end

    initial begin
        // Reset, then idle requests.
        repeat (2) cyc(0, '0, 0);
        repeat (10) cyc(1, '0, 0);
        // Single requester, done on the third busy cycle.
        cyc(1, 8'h01, 0);
        cyc(1, 8'h01, 0);
        cyc(1, 8'h01, 0);
        cyc(1, 8'h00, 1);
        cyc(1, 8'h00, 0);
        // All requesting, done every cycle: full rotation including the wrap.
        repeat (12) cyc(1, 8'hFF, 1);
        cyc(1, 8'h00, 1);
        // Owner 2 holds through a dropped request.
        cyc(0, '0, 0);
        cyc(1, 8'h04, 0);
        repeat (5) cyc(1, 8'h00, 0);
        cyc(1, 8'h00, 1);
        cyc(1, 8'h00, 0);
        // Pointer at 5, ports 0 and 5 requesting.
        cyc(0, '0, 0);
        cyc(1, 8'h10, 0);
        cyc(1, 8'h00, 1);
        cyc(1, 8'h21, 0);
        cyc(1, 8'h21, 1);
        cyc(1, 8'h21, 1);
        // Former owner as the sole requester re-wins.
        cyc(1, 8'h20, 1);
        cyc(1, 8'h20, 1);
        // Reset during a held grant; iDone in IDLE ignored.
        cyc(1, 8'h08, 0);
        cyc(0, 8'h08, 0);
        cyc(1, 8'h00, 1);
        // Grant held with no iDone long enough for the watchdog.
        cyc(1, 8'h01, 0);
        repeat (20) cyc(1, 8'h03, 0);
        cyc(1, 8'h00, 1);
        // Random traffic, frequent done.
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(99) != 0), N'($urandom), ($urandom_range(2) == 0));
        // Random traffic, sparse done and sparse requests.
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(199) != 0), ($urandom_range(3) == 0) ? N'($urandom) : '0,
                ($urandom_range(39) == 0));
        @(posedge iClk);
        #2;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
